// File: rtl/imem_loadable.sv
// Instruction memory for the fetch stage: cleared after reset, then streamed a program image, then serves fetches.
// Fetch latency is 1 cycle; the load stream is 1 word per cycle while in LOAD.
// ld_ready and fetch_ready come only from the registered state: loads are accepted in LOAD only, fetches in RUN only.
module imem_loadable #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    input  logic        reload,
    input  logic        fetch_req,
    output logic        fetch_ready,
    input  logic [31:0] fetch_addr,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        fault,
    output logic        loaded
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
    localparam logic [29:0]     DEPTH_W  = 30'(DEPTH);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_ptr, clr_ptr_nxt;
    logic [AW-1:0]   wr_ptr, wr_ptr_nxt;

    logic [31:0]     mem [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [31:0]     mem_wdata;

    logic            ld_acc;
    logic            fetch_acc;
    logic            fetch_bad;
    logic [AW-1:0]   fetch_idx;

    assign ld_ready    = (state == S_LOAD);
    assign fetch_ready = (state == S_RUN);
    assign loaded      = (state == S_RUN);

    assign ld_acc      = ld_valid && ld_ready;
    assign fetch_acc   = fetch_req && fetch_ready;
    assign fetch_idx   = fetch_addr[2 +: AW];
    // Misaligned and out-of-range fetches share one response, so a single flag suffices.
    assign fetch_bad   = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:2] >= DEPTH_W);

    // State and pointer registers; reset restarts the clear sweep and drops any partial image.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_CLEAR;
            clr_ptr <= '0;
            wr_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
            wr_ptr  <= wr_ptr_nxt;
        end
    end

    // Next-state, pointer advance and the single shared memory write port (clear sweep or load word).
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        wr_ptr_nxt  = wr_ptr;
        mem_we      = 1'b0;
        mem_waddr   = clr_ptr;
        mem_wdata   = 32'h0;
        case (state)
            S_CLEAR: begin
                mem_we      = 1'b1;
                mem_waddr   = clr_ptr;
                mem_wdata   = 32'h0;
                clr_ptr_nxt = clr_ptr + AW'(1);
                if (clr_ptr == LAST_IDX) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ld_acc) begin
                    mem_we     = 1'b1;
                    mem_waddr  = wr_ptr;
                    mem_wdata  = ld_data;
                    wr_ptr_nxt = wr_ptr + AW'(1);
                    // A full image ends the load even without ld_last.
                    if (ld_last || (wr_ptr == LAST_IDX)) begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (reload) begin
                    state_nxt   = S_CLEAR;
                    clr_ptr_nxt = '0;
                    wr_ptr_nxt  = '0;
                end
            end
            default: begin
                state_nxt   = S_CLEAR;
                clr_ptr_nxt = '0;
                wr_ptr_nxt  = '0;
            end
        endcase
    end

    // Memory array write; contents are not reset, the clear sweep zeroes them.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered fetch response; data and fault hold between responses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= 32'h0;
            fault    <= 1'b0;
        end else begin
            rd_valid <= fetch_acc;
            if (fetch_acc) begin
                if (fetch_bad) begin
                    rd_data <= NOP_INSTR;
                    fault   <= 1'b1;
                end else begin
                    rd_data <= mem[fetch_idx];
                    fault   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable with DEPTH=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// All expected values are hand-computed constants.
module tb_imem_loadable;

    logic        clk;
    logic        rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        reload;
    logic        fetch_req;
    logic        fetch_ready;
    logic [31:0] fetch_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        fault;
    logic        loaded;

    int n_cmp = 0;
    int n_err = 0;

    imem_loadable #(
        .DEPTH     (8),
        .NOP_INSTR (32'h00000013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .reload      (reload),
        .fetch_req   (fetch_req),
        .fetch_ready (fetch_ready),
        .fetch_addr  (fetch_addr),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .fault       (fault),
        .loaded      (loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the block to open the load port.
    task automatic wait_ld_ready();
        int n = 0;
        while (!ld_ready && n < 50) begin
            tick();
            n++;
        end
        check("ld_ready_wait", 32'(ld_ready), 32'h1);
    endtask

    task automatic load_word(input logic [31:0] data, input logic last, input int gap);
        ld_valid = 1'b0;
        repeat (gap) tick();
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Single fetch: check the response one cycle after acceptance.
    task automatic fetch_chk(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_data, input logic exp_fault);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_req  = 1'b0;
        check({tag, "_vld"},   32'(rd_valid), 32'h1);
        check({tag, "_data"},  rd_data, exp_data);
        check({tag, "_fault"}, 32'(fault), 32'(exp_fault));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        reload = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
        repeat (3) tick();

        // Reset values.
        check("rst_rd_valid",    32'(rd_valid),    32'h0);
        check("rst_rd_data",     rd_data,          32'h0);
        check("rst_fault",       32'(fault),       32'h0);
        check("rst_ld_ready",    32'(ld_ready),    32'h0);
        check("rst_fetch_ready", 32'(fetch_ready), 32'h0);
        check("rst_loaded",      32'(loaded),      32'h0);

        // CLEAR lasts exactly DEPTH=8 cycles after release.
        rst = 1'b1;
        repeat (7) tick();
        check("clr7_ld_ready",    32'(ld_ready),    32'h0);
        check("clr7_fetch_ready", 32'(fetch_ready), 32'h0);
        tick();
        check("clr8_ld_ready",    32'(ld_ready),    32'h1);
        check("clr8_loaded",      32'(loaded),      32'h0);

        // Three-word image with gaps on ld_valid.
        load_word(32'h00800113, 1'b0, 2);
        load_word(32'h00400093, 1'b0, 1);
        check("ld2_loaded", 32'(loaded), 32'h0);
        load_word(32'h002081b3, 1'b1, 3);
        check("ld3_loaded",      32'(loaded),      32'h1);
        check("ld3_ld_ready",    32'(ld_ready),    32'h0);
        check("ld3_fetch_ready", 32'(fetch_ready), 32'h1);

        fetch_chk("f8",  32'd8,  32'h002081b3, 1'b0);
        fetch_chk("f12", 32'd12, 32'h00000000, 1'b0);
        fetch_chk("f28", 32'd28, 32'h00000000, 1'b0);
        fetch_chk("f6",  32'd6,  32'h00000013, 1'b1);
        tick();
        check("idle_vld",   32'(rd_valid), 32'h0);
        check("idle_hold",  rd_data,       32'h00000013);
        check("idle_fault", 32'(fault),    32'h1);
        fetch_chk("f32", 32'd32, 32'h00000013, 1'b1);
        fetch_chk("fhi", 32'h80000000, 32'h00000013, 1'b1);

        // Back-to-back fetches.
        fetch_req = 1'b1; fetch_addr = 32'd0;
        tick();
        check("b2b0_vld", 32'(rd_valid), 32'h1);
        check("b2b0",     rd_data,       32'h00800113);
        fetch_addr = 32'd4;
        tick();
        check("b2b1_vld", 32'(rd_valid), 32'h1);
        check("b2b1",     rd_data,       32'h00400093);
        fetch_addr = 32'd8;
        tick();
        check("b2b2_vld", 32'(rd_valid), 32'h1);
        check("b2b2",     rd_data,       32'h002081b3);
        check("b2b2_flt", 32'(fault),    32'h0);
        fetch_req = 1'b0;
        tick();
        check("b2b_end_vld", 32'(rd_valid), 32'h0);

        // Reload together with a fetch: old contents answered, then CLEAR.
        reload = 1'b1; fetch_req = 1'b1; fetch_addr = 32'd0;
        tick();
        reload = 1'b0; fetch_req = 1'b0;
        check("rl_vld",    32'(rd_valid),    32'h1);
        check("rl_data",   rd_data,          32'h00800113);
        check("rl_loaded", 32'(loaded),      32'h0);
        check("rl_fready", 32'(fetch_ready), 32'h0);
        repeat (7) tick();
        check("rl_clr7", 32'(ld_ready), 32'h0);
        tick();
        check("rl_clr8", 32'(ld_ready), 32'h1);
        load_word(32'h40208233, 1'b1, 0);
        fetch_chk("rl_f0", 32'd0, 32'h40208233, 1'b0);
        fetch_chk("rl_f4", 32'd4, 32'h00000000, 1'b0);

        // Full image without ld_last ends LOAD after the 8th word.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        wait_ld_ready();
        for (int i = 0; i < 7; i++) load_word(32'hA0000000 + 32'(i), 1'b0, 0);
        check("full7_loaded", 32'(loaded), 32'h0);
        load_word(32'hA0000007, 1'b0, 0);
        check("full8_loaded", 32'(loaded), 32'h1);
        ld_valid = 1'b1; ld_data = 32'hDEADBEEF;
        check("full9_ld_ready", 32'(ld_ready), 32'h0);
        tick();
        ld_valid = 1'b0;
        fetch_chk("full_f28", 32'd28, 32'hA0000007, 1'b0);
        fetch_chk("full_f0",  32'd0,  32'hA0000000, 1'b0);

        // Reset mid-LOAD discards the partial image.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        wait_ld_ready();
        load_word(32'hAAAA0001, 1'b0, 0);
        load_word(32'hAAAA0002, 1'b0, 0);
        rst = 1'b0;
        tick();
        check("mid_rst_ld_ready", 32'(ld_ready), 32'h0);
        rst = 1'b1;
        repeat (7) tick();
        check("mid_clr7", 32'(ld_ready), 32'h0);
        tick();
        check("mid_clr8", 32'(ld_ready), 32'h1);
        load_word(32'h12345678, 1'b1, 0);
        fetch_chk("mid_f0", 32'd0, 32'h12345678, 1'b0);
        fetch_chk("mid_f4", 32'd4, 32'h00000000, 1'b0);

        // Reset mid-RUN drops the pending response.
        fetch_req = 1'b1; fetch_addr = 32'd0; rst = 1'b0;
        tick();
        fetch_req = 1'b0;
        check("run_rst_vld",  32'(rd_valid), 32'h0);
        check("run_rst_data", rd_data,       32'h0);
        check("run_rst_ldd",  32'(loaded),   32'h0);
        rst = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
